// File: rtl/f_ifu.sv
// ---------------------------------------------------------------------------
// f_ifu - Fetch stage (F) of the P7 pipelined MIPS core.
//
// Owns the PC register, picks the next PC from the D-stage redirect controls,
// CP0 request/EPC and the hazard-unit stall, drives the instruction-memory
// address and classifies fetch address errors (AdEL).
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   F_PC_WE         : PC write enable (0 = stall, hold PC; Req overrides)
//   Req             : CP0 exception/interrupt request -> HANDLER_PC
//   D_eret, EPC     : eret in D, and its return target
//   D_NPC_sel       : 0 PC+4, 1 branch, 2 j/jal, 3 jr/jalr
//   D_b_taken       : branch condition (used when D_NPC_sel = 1)
//   D_PC            : PC of the D-stage instruction (base for targets)
//   D_imm16/D_imm26 : branch offset / jump index
//   D_rs            : forwarded rs value for jr/jalr
//   D_is_jump       : D holds a branch/jump, so F holds its delay slot
//   i_inst_addr     : instruction-memory address (= F_PC)
//   i_inst_rdata    : instruction-memory read data (combinational)
//   F_PC, F_Instr, F_ExcCode, F_BD : outputs latched by the F/D register
// ---------------------------------------------------------------------------
module f_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_PC_WE,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic [1:0]  D_NPC_sel,
  input  logic        D_b_taken,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs,
  input  logic        D_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD
);

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;
  logic        adel;

  // Targets are formed from D_PC, not F_PC: the instruction in F when the
  // branch resolves is the delay slot and always executes.
  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{D_imm16[15]}}, D_imm16, 2'b00};
  assign br_target = D_PC + 32'd4 + br_offset;
  assign j_target  = {D_PC[31:28], D_imm26, 2'b00};

  // Redirect selection below the Req/stall level. eret has no delay slot;
  // the hazard unit flushes F/D, this block only redirects.
  always_comb begin
    next_pc = pc_plus4;
    if (D_eret) begin
      next_pc = EPC;
    end else begin
      unique case (D_NPC_sel)
        NPC_BR:  next_pc = D_b_taken ? br_target : pc_plus4;
        NPC_J:   next_pc = j_target;
        NPC_JR:  next_pc = D_rs;
        default: next_pc = pc_plus4;
      endcase
    end
  end

  // Req beats the stall: a pending exception must not be lost because the
  // pipeline happens to be held. A stalled redirect is simply dropped; D is
  // held too, so it is re-evaluated next cycle.
  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (Req)     pc <= HANDLER_PC;
    else if (F_PC_WE) pc <= next_pc;
  end

  // Bad fetch addresses (including jr targets, which are loaded unchanged)
  // are flagged here at fetch time; the memory word is replaced by a nop.
  assign adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  assign i_inst_addr = pc;
  assign F_PC        = pc;
  assign F_Instr     = adel ? 32'd0 : i_inst_rdata;
  assign F_ExcCode   = adel ? EXC_ADEL : EXC_NONE;
  assign F_BD        = D_is_jump;

endmodule

// File: tb/tb_f_ifu.sv
// ---------------------------------------------------------------------------
// tb_f_ifu - directed self-checking bench for the fetch stage.
// Inputs change 1 time unit after posedge; outputs are checked at that point,
// well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_f_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic        F_PC_WE;
  logic        Req;
  logic        D_eret;
  logic [31:0] EPC;
  logic [1:0]  D_NPC_sel;
  logic        D_b_taken;
  logic [31:0] D_PC;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_rs;
  logic        D_is_jump;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic [4:0]  F_ExcCode;
  logic        F_BD;

  int total = 0;
  int bad   = 0;

  f_ifu dut (
    .clk          (clk),
    .reset        (reset),
    .F_PC_WE      (F_PC_WE),
    .Req          (Req),
    .D_eret       (D_eret),
    .EPC          (EPC),
    .D_NPC_sel    (D_NPC_sel),
    .D_b_taken    (D_b_taken),
    .D_PC         (D_PC),
    .D_imm16      (D_imm16),
    .D_imm26      (D_imm26),
    .D_rs         (D_rs),
    .D_is_jump    (D_is_jump),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_PC         (F_PC),
    .F_Instr      (F_Instr),
    .F_ExcCode    (F_ExcCode),
    .F_BD         (F_BD)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PC plus full set of fetch outputs for a legal/illegal address
  task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic exc);
    chk({tag, "_pc"},   F_PC, pc);
    chk({tag, "_addr"}, i_inst_addr, pc);
    chk({tag, "_exc"},  {27'd0, F_ExcCode}, exc ? 32'd4 : 32'd0);
    chk({tag, "_ins"},  F_Instr, exc ? 32'd0 : i_inst_rdata);
  endtask

  initial begin
    reset = 1'b1; F_PC_WE = 1'b1; Req = 1'b0; D_eret = 1'b0; EPC = 32'd0;
    D_NPC_sel = 2'd0; D_b_taken = 1'b0; D_PC = 32'd0; D_imm16 = 16'd0;
    D_imm26 = 26'd0; D_rs = 32'd0; D_is_jump = 1'b0; i_inst_rdata = 32'h1234_5678;

    // reset state
    step();
    chk_fetch("reset", 32'h3000, 1'b0);
    chk("reset_bd", {31'd0, F_BD}, 32'd0);
    reset = 1'b0;

    // free-running sequential fetch
    step(); chk_fetch("seq1", 32'h3004, 1'b0);
    i_inst_rdata = 32'hDEAD_BEEF;
    step(); chk_fetch("seq2", 32'h3008, 1'b0);
    step(); chk_fetch("seq3", 32'h300C, 1'b0);

    // taken branch backwards: 3010 + 4 - 8 = 300C
    D_PC = 32'h3010; D_NPC_sel = 2'd1; D_b_taken = 1'b1; D_imm16 = 16'hFFFE;
    step(); chk_fetch("br_taken", 32'h300C, 1'b0);
    // not taken -> PC + 4
    D_b_taken = 1'b0;
    step(); chk_fetch("br_not", 32'h3010, 1'b0);

    // j: {0, C10, 00} = 3040
    D_NPC_sel = 2'd2; D_imm26 = 26'h000_0C10;
    step(); chk_fetch("j", 32'h3040, 1'b0);

    // jr misaligned: loaded unchanged, AdEL at fetch
    D_NPC_sel = 2'd3; D_rs = 32'h3001;
    step(); chk_fetch("jr_mis", 32'h3001, 1'b1);

    // stall with a pending jump: PC holds two cycles
    D_NPC_sel = 2'd2; F_PC_WE = 1'b0;
    step(); chk("stall1", F_PC, 32'h3001);
    step(); chk("stall2", F_PC, 32'h3001);
    // Req during stall wins
    Req = 1'b1;
    step(); chk_fetch("req_stall", 32'h4180, 1'b0);
    Req = 1'b0; F_PC_WE = 1'b1;

    // eret beats a simultaneous jump select
    D_eret = 1'b1; EPC = 32'h3024;
    step(); chk_fetch("eret", 32'h3024, 1'b0);
    // Req and eret together: Req wins
    Req = 1'b1;
    step(); chk("req_eret", F_PC, 32'h4180);
    Req = 1'b0;
    // stalled eret: held
    F_PC_WE = 1'b0;
    step(); chk("eret_stall", F_PC, 32'h4180);
    D_eret = 1'b0; F_PC_WE = 1'b1;

    // range boundaries via jr
    D_NPC_sel = 2'd3; D_rs = 32'h7000;
    step(); chk_fetch("jr_7000", 32'h7000, 1'b1);
    D_rs = 32'h6FFC;
    step(); chk_fetch("jr_6ffc", 32'h6FFC, 1'b0);
    // sequential past IM_HI: no wrap, AdEL
    D_NPC_sel = 2'd0;
    step(); chk_fetch("past_hi", 32'h7000, 1'b1);
    D_NPC_sel = 2'd3; D_rs = 32'h2FFC;
    step(); chk_fetch("jr_2ffc", 32'h2FFC, 1'b1);
    D_rs = 32'h3000;
    step(); chk_fetch("jr_3000", 32'h3000, 1'b0);

    // delay-slot flag is combinational
    D_is_jump = 1'b1;
    #1 chk("bd_set", {31'd0, F_BD}, 32'd1);
    D_is_jump = 1'b0;
    #1 chk("bd_clr", {31'd0, F_BD}, 32'd0);

    // modulo-2^32 arithmetic: FFFFFFFC + 4 -> 0
    D_rs = 32'hFFFF_FFFC;
    step(); chk_fetch("jr_top", 32'hFFFF_FFFC, 1'b1);
    D_NPC_sel = 2'd0;
    step(); chk_fetch("wrap", 32'h0000_0000, 1'b1);

    // forward branch with positive offset from D_PC (not F_PC)
    D_PC = 32'h3100; D_NPC_sel = 2'd1; D_b_taken = 1'b1; D_imm16 = 16'h0003;
    step(); chk_fetch("br_fwd", 32'h3110, 1'b0);

    // reset mid-stall wins
    D_NPC_sel = 2'd0; F_PC_WE = 1'b0; reset = 1'b1;
    step(); chk_fetch("reset_stall", 32'h3000, 1'b0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
